// File: rtl/sprite_layer.sv
// sprite_layer: scaled ROM sprite overlaid on a background pixel stream, with per-frame opaque hit count.
// Optional horizontal mirroring (flip_x port) is built when SPRITE_FLIP_EN is defined.
module sprite_layer #(
  parameter int         SPR_W       = 11,
  parameter int         SPR_H       = 22,
  parameter int         SCALE_SHIFT = 2,
  parameter int         ADDR_W      = 8,
  parameter int         ROM_LAT     = 1,
  parameter logic [3:0] TRANSP_IDX  = 4'h0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              sprite_en,
`ifdef SPRITE_FLIP_EN
  input  logic              flip_x,
`endif
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [3:0]        rom_q,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [15:0]       hit_count
);
  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_SHIFT);
  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic              sen_q, sen_d;
  logic [10:0]       rel_x, rel_y, col, row;
  logic [ADDR_W-1:0] col_eff;
  logic              in_box;
  logic [13:0]       pipe_q [ROM_LAT];
  logic [13:0]       pipe_d [ROM_LAT];
  logic [13:0]       dly;
  logic              opaque, cnt_inc;
  logic [11:0]       rgb_q, rgb_d;
  logic [15:0]       cnt_q, cnt_d, hit_q, hit_d;
`ifdef SPRITE_FLIP_EN
  logic              sfl_q, sfl_d;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) sfl_q <= 1'b0;
    else          sfl_q <= sfl_d;
  always_comb begin
    sfl_d   = frame_start ? flip_x : sfl_q;
    col_eff = sfl_q ? ADDR_W'(SPR_W - 1) - ADDR_W'(col) : ADDR_W'(col);
  end
`else
  assign col_eff = ADDR_W'(col);
`endif
  always_comb begin
    sx_d  = frame_start ? pos_x : sx_q;
    sy_d  = frame_start ? pos_y : sy_q;
    sen_d = frame_start ? sprite_en : sen_q;
    // 11-bit differences; the >= tests stop off-screen parts from wrapping to 0
    rel_x  = {1'b0, DrawX} - {1'b0, sx_q};
    rel_y  = {1'b0, DrawY} - {1'b0, sy_q};
    in_box = sen_q && (DrawX >= sx_q) && (DrawY >= sy_q) && (rel_x < BOX_W) && (rel_y < BOX_H);
    col    = rel_x >> SCALE_SHIFT;
    row    = rel_y >> SCALE_SHIFT;
    rom_address = in_box ? ADDR_W'(row) * ADDR_W'(SPR_W) + col_eff : '0;
    pipe_d[0] = {in_box, blank, bg_red, bg_green, bg_blue};
    for (int i = 1; i < ROM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    dly     = pipe_q[ROM_LAT-1];
    opaque  = dly[13] && (rom_q != TRANSP_IDX);
    cnt_inc = opaque && dly[12];
    rgb_d   = !dly[12] ? 12'h000 : opaque ? {pal_red, pal_green, pal_blue} : dly[11:0];
    hit_d   = frame_start ? cnt_q : hit_q;
    cnt_d   = frame_start ? {15'd0, cnt_inc} :
              (cnt_inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q  <= '0;
      sy_q  <= '0;
      sen_q <= 1'b0;
      rgb_q <= '0;
      cnt_q <= '0;
      hit_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      sen_q <= sen_d;
      rgb_q <= rgb_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign hit_count = hit_q;
endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: directed checks of sprite_layer with a 1-cycle ROM and a fixed palette mapping.
module tb_sprite_layer;
  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, frame_start, sprite_en;
  logic [3:0] bg_red, bg_green, bg_blue, rom_q, pal_red, pal_green, pal_blue, red, green, blue;
  logic [7:0] rom_address;
  logic [15:0] hit_count;
  logic [3:0] rom [256];
  int vectors = 0;
  int miss = 0;
  localparam logic [11:0] BG = 12'hA69;
  localparam logic [11:0] P3 = 12'h3C4;

  sprite_layer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .rom_address(rom_address),
    .rom_q(rom_q), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .hit_count(hit_count)
  );

  always #5 vga_clk = ~vga_clk;
  initial rom_q = 4'h0;
  always @(posedge vga_clk) rom_q <= rom[rom_address];
  assign pal_red   = rom_q;
  assign pal_green = rom_q ^ 4'hF;
  assign pal_blue  = rom_q + 4'h1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    DrawX = 10'd0;
    DrawY = 10'd0;
    blank = 1'b0;
  endtask

  task automatic chk_px(input logic [9:0] x, input logic [9:0] y, input logic b,
                        input logic [11:0] exp, input string tag);
    DrawX = x;
    DrawY = y;
    blank = b;
    @(posedge vga_clk); #1;
    idle();
    @(posedge vga_clk); #1;
    chk(tag, {4'h0, red, green, blue}, {4'h0, exp});
  endtask

  task automatic fs();
    idle();
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    {bg_red, bg_green, bg_blue} = BG;
    pos_x = 10'd100;
    pos_y = 10'd50;
    sprite_en = 1'b1;
    DrawX = 10'd100;
    DrawY = 10'd50;
    blank = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 4'h3;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_rgb", {4'h0, red, green, blue}, 16'h0);
    chk("rst_hit", hit_count, 16'h0);
    chk("rst_addr", {8'h0, rom_address}, 16'h0);
    reset_n = 1'b1;
    idle();
    chk_px(10'd100, 10'd50, 1'b1, BG, "no_fs_bg");
    chk("no_fs_hit", hit_count, 16'h0);
    fs();
    chk_px(10'd100, 10'd50, 1'b1, P3, "top_left_pal");
    chk_px(10'd144, 10'd50, 1'b1, BG, "right_of_box");
    chk_px(10'd99, 10'd50, 1'b1, BG, "left_of_box");
    chk_px(10'd143, 10'd137, 1'b1, P3, "bottom_right_pal");
    chk_px(10'd100, 10'd138, 1'b1, BG, "below_box");
    chk_px(10'd100, 10'd50, 1'b0, 12'h000, "blanked");
    DrawX = 10'd108;
    DrawY = 10'd54;
    #1;
    chk("addr_c2_r1", {8'h0, rom_address}, 16'd13);
    idle();
    rom[13] = 4'h0;
    chk_px(10'd108, 10'd54, 1'b1, BG, "transp_tl");
    chk_px(10'd111, 10'd57, 1'b1, BG, "transp_br");
    chk_px(10'd112, 10'd54, 1'b1, P3, "transp_right");
    chk_px(10'd107, 10'd57, 1'b1, P3, "transp_left");
    fs();
    for (int y = 48; y <= 140; y++)
      for (int x = 96; x <= 147; x++) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = 1'b1;
        @(posedge vga_clk); #1;
      end
    idle();
    @(posedge vga_clk); #1;
    fs();
    chk("frame_hits", hit_count, 16'd3856);
    DrawX = 10'd100;
    DrawY = 10'd50;
    blank = 1'b1;
    @(posedge vga_clk); #1;
    idle();
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    chk("fs_excludes_pixel", hit_count, 16'd0);
    fs();
    chk("fs_restart_at_1", hit_count, 16'd1);
    pos_x = 10'd200;
    chk_px(10'd100, 10'd50, 1'b1, P3, "hold_old_pos");
    chk_px(10'd200, 10'd50, 1'b1, BG, "hold_new_pos");
    fs();
    chk_px(10'd200, 10'd50, 1'b1, P3, "moved_new_pos");
    chk_px(10'd100, 10'd50, 1'b1, BG, "moved_old_pos");
    rom[13] = 4'h3;
    pos_x = 10'd620;
    pos_y = 10'd470;
    fs();
    chk_px(10'd620, 10'd470, 1'b1, P3, "edge_tl");
    chk_px(10'd639, 10'd479, 1'b1, P3, "edge_br");
    chk_px(10'd0, 10'd470, 1'b1, BG, "no_wrap_x");
    chk_px(10'd3, 10'd0, 1'b1, BG, "no_wrap_y");
    chk_px(10'd10, 10'd80, 1'b1, BG, "no_wrap_xy");
    chk_px(10'd619, 10'd470, 1'b1, BG, "edge_left");
    chk_px(10'd620, 10'd469, 1'b1, BG, "edge_above");
    sprite_en = 1'b0;
    fs();
    chk("edge_hits", hit_count, 16'd2);
    chk_px(10'd620, 10'd470, 1'b1, BG, "disabled");
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", {4'h0, red, green, blue}, 16'h0);
    chk("async_rst_hit", hit_count, 16'h0);
    sprite_en = 1'b1;
    #3 reset_n = 1'b1;
    chk_px(10'd620, 10'd470, 1'b1, BG, "post_rst_hidden");
    chk("post_rst_hit", hit_count, 16'h0);
    fs();
    chk_px(10'd620, 10'd470, 1'b1, P3, "post_rst_fs");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/sprite_layer.md
SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 Parameter SPR_W, default 11: sprite width in texels.
REQ-002 Parameter SPR_H, default 22: sprite height in texels.
REQ-003 Parameter SCALE_SHIFT, default 2: each texel is drawn as a (1<<SCALE_SHIFT) by (1<<SCALE_SHIFT) pixel square.
REQ-004 Parameter ADDR_W, default 8: ROM address width; SPR_W*SPR_H SHALL be at most 2**ADDR_W.
REQ-005 Parameter ROM_LAT, default 1 (range 1-3): cycles from rom_address to a valid rom_q.
REQ-006 Parameter TRANSP_IDX, default 4'h0: palette index treated as transparent.
REQ-007 Port vga_clk, input, 1: sole clock; all state is on its rising edge.
REQ-008 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-009 Ports DrawX, DrawY, input, 10 each: current pixel coordinate.
REQ-010 Port blank, input, 1: high = visible pixel.
REQ-011 Port frame_start, input, 1: one-cycle pulse at frame boundary.
REQ-012 Ports pos_x, pos_y, input, 10 each: requested sprite top-left.
REQ-013 Port sprite_en, input, 1: requested sprite visibility.
REQ-014 Ports bg_red, bg_green, bg_blue, input, 4 each: background colour, aligned with DrawX.
REQ-015 Port rom_address, output, ADDR_W: texel address to the external ROM.
REQ-016 Port rom_q, input, 4: palette index from the ROM.
REQ-017 Ports pal_red, pal_green, pal_blue, input, 4 each: combinational palette colour of rom_q.
REQ-018 Ports red, green, blue, output, 4 each: registered pixel colour.
REQ-019 Port hit_count, output, 16: opaque sprite pixels drawn in the previous frame.

Function
REQ-020 The block SHALL load pos_x, pos_y and sprite_en into shadow registers only in cycles where frame_start=1; all drawing SHALL use the shadow values.
REQ-021 relX=DrawX-shadow_x and relY=DrawY-shadow_y SHALL be computed in 11 bits; in_box SHALL be 1 iff shadow_en=1, DrawX>=shadow_x, DrawY>=shadow_y, relX<(SPR_W<<SCALE_SHIFT) and relY<(SPR_H<<SCALE_SHIFT).
REQ-022 col=relX>>SCALE_SHIFT and row=relY>>SCALE_SHIFT; rom_address SHALL be combinational row*SPR_W+col when in_box=1, otherwise 0.
REQ-023 in_box, blank and bg_* SHALL be delayed ROM_LAT cycles through a register pipeline so they align with rom_q.
REQ-024 opaque SHALL be 1 iff delayed in_box=1 and rom_q!=TRANSP_IDX.
REQ-025 One cycle after alignment (total latency ROM_LAT+1 cycles from DrawX): delayed blank=0 -> red/green/blue=0; else opaque=1 -> pal_*; else delayed bg_*.
REQ-026 A sprite partially off-screen (x+width>639 or y+height>479) SHALL draw only the visible part, with no wrap to column 0 or row 0.
REQ-027 A 16-bit counter SHALL increment on each cycle with opaque=1 and delayed blank=1, saturating at 16'hFFFF.
REQ-028 When frame_start=1, hit_count SHALL take the counter value excluding that cycle's pixel, and the counter SHALL restart at 1 if that cycle's pixel counts, else 0.

Reset
REQ-029 While reset_n=0: red/green/blue=0, hit_count=0, counter=0, shadow registers=0 (sprite disabled), all pipeline stages=0.
REQ-030 Reset asserted mid-frame SHALL clear state immediately; after release the sprite SHALL stay hidden until the first frame_start.

Configuration
REQ-031 With SPRITE_FLIP_EN defined: extra input flip_x (1 bit) SHALL be latched at frame_start with the position, and when its shadow is 1 the column SHALL be SPR_W-1-col.
REQ-032 Without SPRITE_FLIP_EN: no flip_x port, col used unmodified.

Verification
REQ-033 Reset, then pixels with no frame_start -> RGB equals bg_* after ROM_LAT+1 cycles; hit_count=0.
REQ-034 pos=(100,50), sprite_en=1, frame_start, ROM all 4'h3 -> pixel (100,50) shows pal of index 3; pixels (144,50) and (99,50) show background.
REQ-035 Texel (col 2,row 1) is TRANSP_IDX, rest opaque -> pixels x=108..111, y=54..57 show background; full frame gives hit_count=11*22*16-16=3856.
REQ-036 pos_x changed mid-frame without frame_start -> drawing unchanged until the next frame_start.
REQ-037 pos=(620,470) -> only x 620..639, y 470..479 draw; nothing at x 0..23 or y 0..87.
REQ-038 SPRITE_FLIP_EN defined, flip_x=1, unique texel per address -> pixel (shadow_x,shadow_y) reads rom_address 10.
